time_verifier_arbiter: RTL
==========================

# time_verifier_arbiter

Round-robin scheduler that shares one time-verifier instance among four cycle-timing requesters. A granted channel's CStart/CEnd pair is routed to the verifier, and the verifier's result is captured. If the verifier reports an error, the block clears it through its ErrorRst input. It then reports per-channel pass, fail or timeout. The block sits between the channel interfaces and the single verifier, and is the only driver of the verifier's inputs.

## Interface
- TIMEOUT, 16: grant cycles allowed for the channel's CStart before it is abandoned (2..2^TW−1).
- TW, 5: timeout counter width.

- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, synchronous, active-high; also drives the verifier's Rst.
- Req  in  4  per-channel check request, level.
- CStartIn  in  4  per-channel cycle-start pulse.
- CEndIn  in  4  per-channel cycle-end pulse.
- ClrFlags  in  1  clears ErrFlags and ToFlags.
- VError  in  1  verifier Error output.
- VStart  out  1  to verifier CStart.
- VEnd  out  1  to verifier CEnd.
- VErrorRst  out  1  to verifier ErrorRst.
- Grant  out  4  one-hot grant, registered.
- Done  out  1  one-cycle completion pulse.
- DoneId  out  2  channel index of the completed transaction, valid with Done.
- DoneFail  out  1  verifier reported a timing error, valid with Done.
- DoneTimeout  out  1  CStart never arrived, valid with Done.
- ErrFlags  out  4  sticky per-channel fail flags.
- ToFlags  out  4  sticky per-channel timeout flags.

## Operation
- States: IDLE, GRANT, CHECK, CLEAR, DONE.
- **IDLE**
  - Any Req bit set → GRANT.
  - Winner is the first set bit scanning upward (wrapping) from priority pointer P. P=0 after reset.
  - Grant becomes the one-hot winner; the timeout counter clears.
- **GRANT**
  - VStart = CStartIn[g], VEnd = CEndIn[g].
  - CStartIn[g]=1 → CHECK, check counter cleared.
  - Otherwise the timeout counter increments. After TIMEOUT consecutive GRANT edges without CStart → DONE with timeout. CStart on the final edge counts as a start (start wins).
- **CHECK**
  - VStart forced 0; VEnd = CEndIn[g].
  - Counter runs 0..4 (five edges). This covers the verifier's expected sequence (CEnd 0, 1, 0 on the three cycles after start) plus one cycle of registered Error latency.
  - VError=1 on any CHECK edge → CLEAR with fail latched.
  - Count 4 reached with VError=0 → DONE, pass.
- **CLEAR**
  - VStart=VEnd=0, VErrorRst=1.
  - Stays while VError=1; VError=0 → DONE. Nominal dwell is 2 cycles.
- **DONE**
  - Done=1 for one cycle; DoneId=g, DoneFail and DoneTimeout reflect the outcome.
  - ErrFlags[g] or ToFlags[g] is set.
  - P ← (g+1) mod 4.
  - → IDLE; Grant clears on the same edge.
- VStart, VEnd and VErrorRst are 0 in every state not listed above.
- A Req drop after grant is ignored; the transaction runs to DONE.
- Inputs from ungranted channels are ignored.
- ClrFlags clears both flag vectors on an edge. If a flag is set on the same edge, the set wins for that bit.

## Timing
- Reset values: Grant=0, Done=0, DoneId=0, DoneFail=0, DoneTimeout=0, ErrFlags=0, ToFlags=0, VStart=0, VEnd=0, VErrorRst=0; state IDLE, P=0.
- VStart, VEnd and VErrorRst are combinational from state, g and channel inputs. All other outputs are registered.
- Req sampled at edge k → Grant visible after edge k.
- CStart sampled at edge t:
  - Pass: Done visible after edge t+6. That is the five CHECK edges t+1..t+5, then DONE.
  - Error entered at verifier edge t+1: VError is seen at edge t+2, giving CLEAR at t+2..t+4 and Done after t+5.
- Minimum Req-to-Done: 1 grant edge + 5 check edges + 1 DONE cycle.
- Back-to-back: one idle cycle between Done and the next Grant.
- Rst during any state: next cycle is IDLE with reset values. Done is not emitted for the aborted transaction. The verifier resets concurrently via the shared Rst.

## Test plan
- **Pass:** Req=0010; CStartIn[1]=1 at edge t; CEndIn[1]=0,1,0 on edges t+1..t+3 → Done after t+6, DoneId=1, DoneFail=0, flags unchanged.
- **Early end:** CEnd=1 at t+1 on channel 2 → CLEAR with VErrorRst=1 for 2 cycles, Done with DoneFail=1, ErrFlags=0100, VError=0 afterwards.
- **Round-robin:** Req=1111 held → grant order 0,1,2,3,0. Then with Req=1001 after channel 3 completes → next grant is 0.
- **Timeout:** Req[3]=1 with no CStart → Done after 16 grant cycles, DoneTimeout=1, ToFlags=1000. A later channel-3 pass leaves ToFlags set.
- **Flag race:** ClrFlags=1 on the DONE edge of a channel-0 fail with ErrFlags=0110 beforehand → ErrFlags=0001.
- **Reset mid-check:** Rst at the third CHECK edge → all outputs at reset values, no Done. A new Req then completes normally with P=0 priority.

Source files
------------

// File: rtl/time_verifier_arbiter.sv
// time_verifier_arbiter
//
// Purpose:
//   Shares a single cycle-timing verifier among four requesting channels.
//   Channels are served round-robin. The granted channel's CStart/CEnd pulses
//   are steered onto the verifier. The verifier's Error output is watched for
//   a fixed check window. If an error is reported, it is cleared through the
//   verifier's ErrorRst. The outcome is then reported as a one-cycle Done pulse
//   with pass / fail / timeout qualifiers and sticky per-channel flags.
//
// Ports:
//   Clk          rising-edge clock
//   Rst          synchronous active-high reset (shared with the verifier)
//   Req[3:0]     per-channel check request (level)
//   CStartIn[3:0] per-channel cycle-start pulse
//   CEndIn[3:0]  per-channel cycle-end pulse
//   ClrFlags     clears ErrFlags/ToFlags (a same-edge set wins)
//   VError       verifier Error output
//   VStart       to verifier CStart (combinational)
//   VEnd         to verifier CEnd (combinational)
//   VErrorRst    to verifier ErrorRst (combinational)
//   Grant[3:0]   registered one-hot grant
//   Done         one-cycle completion pulse
//   DoneId[1:0]  channel that completed, valid with Done
//   DoneFail     verifier reported an error, valid with Done
//   DoneTimeout  CStart never arrived, valid with Done
//   ErrFlags[3:0] sticky per-channel fail flags
//   ToFlags[3:0] sticky per-channel timeout flags

module time_verifier_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic [3:0] CStartIn,
  input  logic [3:0] CEndIn,
  input  logic       ClrFlags,
  input  logic       VError,
  output logic       VStart,
  output logic       VEnd,
  output logic       VErrorRst,
  output logic [3:0] Grant,
  output logic       Done,
  output logic [1:0] DoneId,
  output logic       DoneFail,
  output logic       DoneTimeout,
  output logic [3:0] ErrFlags,
  output logic [3:0] ToFlags
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CHECK,
    CLEAR,
    DONE
  } state_t;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    CHK_LAST = 3'd4;

  state_t     state;
  state_t     stateNext;
  logic [1:0] ptr;
  logic [1:0] gIdx;
  logic [1:0] winIdx;
  logic       anyReq;
  logic [TW-1:0] toCnt;
  logic [2:0] chkCnt;
  logic       failLat;
  logic       toLat;
  logic [3:0] gMask;
  logic [3:0] errSet;
  logic [3:0] toSet;

  // Round-robin pick: scan upward from the priority pointer with wrap-around.
  // The loop runs from the farthest offset down to the nearest so that the
  // nearest requesting channel is the last (and therefore winning) assignment.
  always_comb begin
    winIdx = ptr;
    anyReq = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (Req[ptr + 2'(i)]) begin
        winIdx = ptr + 2'(i);
        anyReq = 1'b1;
      end
    end
  end

  // Flag set masks only assert on the DONE edge for the granted channel.
  always_comb begin
    gMask  = 4'b0001 << gIdx;
    errSet = ((state == DONE) && failLat) ? gMask : 4'b0000;
    toSet  = ((state == DONE) && toLat)   ? gMask : 4'b0000;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode and the combinational verifier drive. Only the granted
  // channel is ever routed to the verifier. CStart is blocked once checking
  // starts, so a stray start cannot restart the verifier mid-sequence.
  // In GRANT a start on the final timeout edge still counts as a start.
  always_comb begin
    stateNext = state;
    VStart    = 1'b0;
    VEnd      = 1'b0;
    VErrorRst = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) stateNext = GRANT;
      end
      GRANT: begin
        VStart = CStartIn[gIdx];
        VEnd   = CEndIn[gIdx];
        if (CStartIn[gIdx])      stateNext = CHECK;
        else if (toCnt == TO_LAST) stateNext = DONE;
      end
      CHECK: begin
        VEnd = CEndIn[gIdx];
        if (VError)                 stateNext = CLEAR;
        else if (chkCnt == CHK_LAST) stateNext = DONE;
      end
      CLEAR: begin
        VErrorRst = 1'b1;
        if (!VError) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: grant capture, the timeout and check counters, outcome latches
  // and the registered completion outputs. Done and its qualifiers are
  // loaded on the DONE edge, so they appear together with Grant dropping.
  // A clear request and a same-edge set combine so the set survives.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr         <= 2'd0;
      gIdx        <= 2'd0;
      Grant       <= 4'b0000;
      toCnt       <= '0;
      chkCnt      <= 3'd0;
      failLat     <= 1'b0;
      toLat       <= 1'b0;
      Done        <= 1'b0;
      DoneId      <= 2'd0;
      DoneFail    <= 1'b0;
      DoneTimeout <= 1'b0;
      ErrFlags    <= 4'b0000;
      ToFlags     <= 4'b0000;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            gIdx    <= winIdx;
            Grant   <= 4'b0001 << winIdx;
            toCnt   <= '0;
            failLat <= 1'b0;
            toLat   <= 1'b0;
          end
        end
        GRANT: begin
          if (CStartIn[gIdx])        chkCnt <= 3'd0;
          else if (toCnt == TO_LAST) toLat  <= 1'b1;
          else                       toCnt  <= toCnt + 1'b1;
        end
        CHECK: begin
          if (VError)                  failLat <= 1'b1;
          else if (chkCnt != CHK_LAST) chkCnt  <= chkCnt + 3'd1;
        end
        DONE: begin
          Done        <= 1'b1;
          DoneId      <= gIdx;
          DoneFail    <= failLat;
          DoneTimeout <= toLat;
          ptr         <= gIdx + 2'd1;
          Grant       <= 4'b0000;
        end
        default: begin
        end
      endcase
      ErrFlags <= (ClrFlags ? 4'b0000 : ErrFlags) | errSet;
      ToFlags  <= (ClrFlags ? 4'b0000 : ToFlags)  | toSet;
    end
  end

endmodule
